// File: rtl/hdr_exposure_sequencer.sv
// hdr_exposure_sequencer
// Runs a three-exposure HDR burst (or a single capture) in the p_clk domain:
// programs each exposure through the SCCB writer with a req/ack handshake,
// discards settling frames, records the DDR slot of each exposed frame and
// pulses proc_start once every frame of the burst is complete.
module hdr_exposure_sequencer #(
  parameter logic [15:0] EXP0        = 16'h0040,
  parameter logic [15:0] EXP1        = 16'h0100,
  parameter logic [15:0] EXP2        = 16'h0400,
  parameter logic [15:0] EXP_DEF     = 16'h0100,
  parameter int unsigned SKIP_FRAMES = 0,
  parameter logic [19:0] ACK_TIMEOUT = 20'hFFFFF
) (
  input  logic        p_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hdr_en,
  input  logic        frame_done,
  input  logic [2:0]  last_frame,
  output logic        exp_req,
  output logic [15:0] exp_val,
  input  logic        exp_ack,
  output logic        busy,
  output logic        proc_start,
  output logic [2:0]  slot0,
  output logic [2:0]  slot1,
  output logic [2:0]  slot2,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SET_EXP = 3'd1;
  localparam logic [2:0] ST_SKIP    = 3'd2;
  localparam logic [2:0] ST_ARM     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RESTORE = 3'd5;

  localparam logic [1:0] SKIP_TGT = SKIP_FRAMES[1:0];

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        hdr_q, hdr_d;
  logic [1:0]  skip_q, skip_d;
  logic [19:0] tmo_q, tmo_d;
  logic [2:0]  ovr_q, ovr_d;
  logic        ovr_on_q, ovr_on_d;
  logic        exp_req_q, exp_req_d;
  logic [15:0] exp_val_q, exp_val_d;
  logic        busy_q, busy_d;
  logic        proc_q, proc_d;
  logic [2:0]  slot0_q, slot0_d;
  logic [2:0]  slot1_q, slot1_d;
  logic [2:0]  slot2_q, slot2_d;
  logic        err_to_q, err_to_d;
  logic        err_ov_q, err_ov_d;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hdr_d     = hdr_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    ovr_d     = ovr_q;
    ovr_on_d  = ovr_on_q;
    exp_val_d = exp_val_q;
    proc_d    = 1'b0;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    slot2_d   = slot2_q;
    err_to_d  = err_to_q;
    err_ov_d  = err_ov_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
          idx_d    = 2'd0;
          hdr_d    = hdr_en;
          ovr_on_d = 1'b0;
          ovr_d    = '0;
          state_d  = hdr_en ? ST_SET_EXP : ST_ARM;
        end
      end
      ST_SET_EXP: begin
        if (exp_ack) begin
          skip_d  = '0;
          state_d = ST_SKIP;
        end else if (tmo_q == ACK_TIMEOUT - 20'd1) begin
          err_to_d = 1'b1;
          ovr_on_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 20'd1;
        end
      end
      ST_SKIP: begin
        // A frame_done in the cycle the target is already met is not a settling frame.
        if (skip_q == SKIP_TGT) begin
          state_d = ST_ARM;
        end else if (frame_done && skip_q != 2'd3) begin
          skip_d = skip_q + 2'd1;
        end
      end
      ST_ARM: begin
        if (frame_done) begin
          case (idx_q)
            2'd0: begin
              slot0_d  = last_frame;
              ovr_on_d = 1'b1;
            end
            2'd1:    slot1_d = last_frame;
            default: slot2_d = last_frame;
          endcase
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_done) begin
          if (!hdr_q) begin
            proc_d   = 1'b1;
            ovr_on_d = 1'b0;
            state_d  = ST_IDLE;
          end else if (idx_q != 2'd2) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SET_EXP;
          end else begin
            proc_d   = 1'b1;
            ovr_on_d = 1'b0;
            state_d  = ST_RESTORE;
          end
        end
      end
      ST_RESTORE: begin
        if (exp_ack) begin
          state_d = ST_IDLE;
        end else if (tmo_q == ACK_TIMEOUT - 20'd1) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 20'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The overrun watch uses the registered enable, so the slot0 pulse itself is
    // not counted while the final HOLD pulse still is.
    if (ovr_on_q && frame_done) begin
      if (ovr_q != 3'd7) ovr_d = ovr_q + 3'd1;
      if (ovr_q == 3'd5) err_ov_d = 1'b1;
    end

    if (state_d != state_q) tmo_d = '0;

    if (state_d == ST_SET_EXP) begin
      case (idx_d)
        2'd0:    exp_val_d = EXP0;
        2'd1:    exp_val_d = EXP1;
        default: exp_val_d = EXP2;
      endcase
    end else if (state_d == ST_RESTORE) begin
      exp_val_d = EXP_DEF;
    end

    exp_req_d = (state_d == ST_SET_EXP) || (state_d == ST_RESTORE);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any burst immediately.
  always_ff @(posedge p_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      hdr_q     <= 1'b0;
      skip_q    <= '0;
      tmo_q     <= '0;
      ovr_q     <= '0;
      ovr_on_q  <= 1'b0;
      exp_req_q <= 1'b0;
      exp_val_q <= '0;
      busy_q    <= 1'b0;
      proc_q    <= 1'b0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      slot2_q   <= '0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hdr_q     <= hdr_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      ovr_on_q  <= ovr_on_d;
      exp_req_q <= exp_req_d;
      exp_val_q <= exp_val_d;
      busy_q    <= busy_d;
      proc_q    <= proc_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      slot2_q   <= slot2_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
    end
  end

  assign exp_req     = exp_req_q;
  assign exp_val     = exp_val_q;
  assign busy        = busy_q;
  assign proc_start  = proc_q;
  assign slot0       = slot0_q;
  assign slot1       = slot1_q;
  assign slot2       = slot2_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_hdr_exposure_sequencer.sv
// tb_hdr_exposure_sequencer
// Two sequencers (SKIP_FRAMES 0 and 1, ACK_TIMEOUT 16) share start/frame
// stimulus, each with its own ack responder. A burst-script model predicts
// every output each cycle; directed phases pin the model with literal values.
module tb_hdr_exposure_sequencer;

  localparam int TMO = 16;
  localparam int K_W = 0;  // exposure write, waits for ack
  localparam int K_S = 1;  // settling frames to discard
  localparam int K_L = 2;  // frame to record into a slot
  localparam int K_F = 3;  // frame that completes an exposure

  logic clk, rst_n, start, hdr_en, frame_done;
  logic [2:0] last_frame;
  logic ack_w[2];
  logic req_w[2];
  logic [15:0] val_w[2];
  logic busy_w[2], proc_w[2], eto_w[2], eov_w[2];
  logic [2:0] s0_w[2], s1_w[2], s2_w[2];

  hdr_exposure_sequencer #(.SKIP_FRAMES(0), .ACK_TIMEOUT(20'd16)) dut0 (
    .p_clk(clk), .rst_n(rst_n), .start(start), .hdr_en(hdr_en),
    .frame_done(frame_done), .last_frame(last_frame),
    .exp_req(req_w[0]), .exp_val(val_w[0]), .exp_ack(ack_w[0]),
    .busy(busy_w[0]), .proc_start(proc_w[0]),
    .slot0(s0_w[0]), .slot1(s1_w[0]), .slot2(s2_w[0]),
    .err_timeout(eto_w[0]), .err_overrun(eov_w[0]));

  hdr_exposure_sequencer #(.SKIP_FRAMES(1), .ACK_TIMEOUT(20'd16)) dut1 (
    .p_clk(clk), .rst_n(rst_n), .start(start), .hdr_en(hdr_en),
    .frame_done(frame_done), .last_frame(last_frame),
    .exp_req(req_w[1]), .exp_val(val_w[1]), .exp_ack(ack_w[1]),
    .busy(busy_w[1]), .proc_start(proc_w[1]),
    .slot0(s0_w[1]), .slot1(s1_w[1]), .slot2(s2_w[1]),
    .err_timeout(eto_w[1]), .err_overrun(eov_w[1]));

  int n_checks = 0;
  int n_fail = 0;
  int skipn[2] = '{0, 1};
  int ack_dly[2];
  int ack_n[2];
  int proc_cnt[2];
  logic prev_req[2];
  logic [15:0] vseq0[$];
  logic [15:0] vseq1[$];

  // burst script model state
  int a_kind[2][16];
  logic [15:0] a_arg[2][16];
  int s_len[2], s_pos[2], tick[2], scnt[2], ovr_n[2];
  logic ovr_on[2];
  logic e_req[2], e_busy[2], e_proc[2], e_eto[2], e_eov[2];
  logic [15:0] e_val[2];
  logic [2:0] e_slot[2][3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, expv, $time);
    end
  endtask

  task automatic push(input int k, input int kind, input logic [15:0] arg);
    a_kind[k][s_len[k]] = kind;
    a_arg[k][s_len[k]] = arg;
    s_len[k]++;
  endtask

  task automatic enter_head(input int k);
    if (s_pos[k] >= s_len[k]) s_len[k] = 0;
    else if (a_kind[k][s_pos[k]] == K_W) begin
      e_val[k] = a_arg[k][s_pos[k]];
      tick[k] = 0;
    end else if (a_kind[k][s_pos[k]] == K_S) scnt[k] = 0;
  endtask

  task automatic advance(input int k);
    s_pos[k]++;
    enter_head(k);
  endtask

  task automatic model_reset(input int k);
    s_len[k] = 0; s_pos[k] = 0; tick[k] = 0; scnt[k] = 0; ovr_n[k] = 0; ovr_on[k] = 0;
    e_req[k] = 0; e_busy[k] = 0; e_proc[k] = 0; e_eto[k] = 0; e_eov[k] = 0;
    e_val[k] = 16'h0;
    for (int j = 0; j < 3; j++) e_slot[k][j] = 3'd0;
  endtask

  task automatic model_step(input int k);
    int p;
    logic [15:0] ev[3];
    ev[0] = 16'h0040; ev[1] = 16'h0100; ev[2] = 16'h0400;
    e_proc[k] = 1'b0;
    if (s_len[k] == 0) begin
      if (start) begin
        e_eto[k] = 0; e_eov[k] = 0; ovr_on[k] = 0; ovr_n[k] = 0;
        s_pos[k] = 0;
        if (hdr_en) begin
          for (int n = 0; n < 3; n++) begin
            push(k, K_W, ev[n]);
            push(k, K_S, 16'd0);
            push(k, K_L, 16'(n));
            push(k, K_F, (n == 2) ? 16'd1 : 16'd0);
          end
          push(k, K_W, 16'h0100);
        end else begin
          push(k, K_L, 16'd0);
          push(k, K_F, 16'd1);
        end
        enter_head(k);
      end
    end else begin
      p = s_pos[k];
      if (ovr_on[k] && frame_done) begin
        if (ovr_n[k] < 7) ovr_n[k]++;
        if (ovr_n[k] == 6) e_eov[k] = 1'b1;
      end
      case (a_kind[k][p])
        K_W: begin
          if (ack_w[k]) advance(k);
          else begin
            tick[k]++;
            if (tick[k] == TMO) begin
              e_eto[k] = 1'b1; s_len[k] = 0; ovr_on[k] = 0;
            end
          end
        end
        K_S: begin
          if (scnt[k] == skipn[k]) advance(k);
          else if (frame_done && scnt[k] < 3) scnt[k]++;
        end
        K_L: begin
          if (frame_done) begin
            e_slot[k][a_arg[k][p][1:0]] = last_frame;
            if (a_arg[k][p] == 16'd0) ovr_on[k] = 1'b1;
            advance(k);
          end
        end
        default: begin
          if (frame_done) begin
            if (a_arg[k][p] != 16'd0) begin
              e_proc[k] = 1'b1; ovr_on[k] = 1'b0;
            end
            advance(k);
          end
        end
      endcase
    end
    e_busy[k] = (s_len[k] != 0);
    e_req[k] = e_busy[k] && (a_kind[k][s_pos[k]] == K_W);
  endtask

  // model advances on each sampling edge, resets with rst_n
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_reset(k);
        else model_step(k);
      end
    end
  end

  // ack responders: ack_dly<0 holds ack high, otherwise ack after ack_dly cycles of req
  initial begin
    for (int k = 0; k < 2; k++) begin ack_w[k] = 1'b0; ack_n[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ack_dly[k] < 0) ack_w[k] = 1'b1;
        else if (ack_w[k]) begin ack_w[k] = 1'b0; ack_n[k] = 0; end
        else if (req_w[k]) begin
          if (ack_n[k] >= ack_dly[k]) ack_w[k] = 1'b1;
          else ack_n[k]++;
        end else ack_n[k] = 0;
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    for (int k = 0; k < 2; k++) begin prev_req[k] = 1'b0; proc_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          chk(k, "exp_req", 32'(req_w[k]), 32'(e_req[k]));
          chk(k, "exp_val", 32'(val_w[k]), 32'(e_val[k]));
          chk(k, "busy", 32'(busy_w[k]), 32'(e_busy[k]));
          chk(k, "proc_start", 32'(proc_w[k]), 32'(e_proc[k]));
          chk(k, "slot0", 32'(s0_w[k]), 32'(e_slot[k][0]));
          chk(k, "slot1", 32'(s1_w[k]), 32'(e_slot[k][1]));
          chk(k, "slot2", 32'(s2_w[k]), 32'(e_slot[k][2]));
          chk(k, "err_timeout", 32'(eto_w[k]), 32'(e_eto[k]));
          chk(k, "err_overrun", 32'(eov_w[k]), 32'(e_eov[k]));
          if (proc_w[k]) proc_cnt[k]++;
          if (req_w[k] && !prev_req[k]) begin
            if (k == 0) vseq0.push_back(val_w[k]);
            else vseq1.push_back(val_w[k]);
          end
        end
      end
      for (int k = 0; k < 2; k++) prev_req[k] = req_w[k];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic h);
    @(negedge clk); start = 1'b1; hdr_en = h;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic frame(input logic [2:0] lf);
    @(negedge clk); frame_done = 1'b1; last_frame = lf;
    @(negedge clk); frame_done = 1'b0;
  endtask

  task automatic clear_mon();
    proc_cnt[0] = 0; proc_cnt[1] = 0;
    vseq0.delete(); vseq1.delete();
  endtask

  function automatic int pick_dly();
    int t;
    t = $urandom_range(0, 7);
    case (t)
      0: return -1;
      1: return 0;
      2: return 1;
      3: return 2;
      4: return 3;
      5: return 5;
      6: return 20;
      default: return 1;
    endcase
  endfunction

  task automatic chk_vseq(input int k);
    logic [15:0] want[4];
    logic [15:0] got;
    int sz;
    want[0] = 16'h0040; want[1] = 16'h0100; want[2] = 16'h0400; want[3] = 16'h0100;
    sz = (k == 0) ? vseq0.size() : vseq1.size();
    chk(k, "exp_val seq length", 32'(sz), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = 16'hdead;
      if (i < sz) got = (k == 0) ? vseq0[i] : vseq1[i];
      chk(k, "exp_val seq item", 32'(got), 32'(want[i]));
    end
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst exp_req", 32'(req_w[k]), 32'd0);
      chk(k, "rst exp_val", 32'(val_w[k]), 32'd0);
      chk(k, "rst busy", 32'(busy_w[k]), 32'd0);
      chk(k, "rst proc_start", 32'(proc_w[k]), 32'd0);
      chk(k, "rst slots", {23'd0, s0_w[k], s1_w[k], s2_w[k]}, 32'd0);
      chk(k, "rst errors", {30'd0, eto_w[k], eov_w[k]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; hdr_en = 1'b0; frame_done = 1'b0; last_frame = 3'd0;
    ack_dly[0] = 3; ack_dly[1] = 3;
    #2 rst_n = 1'b0;
    idle(2);
    chk_reset_vals();
    rst_n = 1'b1;
    idle(2);

    // HDR burst: frames 12 cycles apart, last_frame = 1,2,3,4,5,0,1,2,3,4
    clear_mon();
    pulse_start(1'b1);
    for (int i = 1; i <= 10; i++) begin
      idle(11);
      frame(3'(i % 6));
    end
    idle(25);
    chk(0, "hdr slots", {23'd0, s0_w[0], s1_w[0], s2_w[0]}, {23'd0, 3'd1, 3'd3, 3'd5});
    chk(1, "hdr slots", {23'd0, s0_w[1], s1_w[1], s2_w[1]}, {23'd0, 3'd2, 3'd5, 3'd2});
    chk(0, "hdr proc count", 32'(proc_cnt[0]), 32'd1);
    chk(1, "hdr proc count", 32'(proc_cnt[1]), 32'd1);
    chk(0, "hdr err_overrun", 32'(eov_w[0]), 32'd0);
    chk(1, "skip1 err_overrun", 32'(eov_w[1]), 32'd1);
    chk(0, "hdr busy after", 32'(busy_w[0]), 32'd0);
    chk(1, "hdr busy after", 32'(busy_w[1]), 32'd0);
    chk_vseq(0);
    chk_vseq(1);

    // single frame; start coincident with a frame, start pulsed again in HOLD
    clear_mon();
    @(negedge clk); start = 1'b1; hdr_en = 1'b0; frame_done = 1'b1; last_frame = 3'd3;
    @(negedge clk); start = 1'b0; frame_done = 1'b0;
    idle(4);
    frame(3'd4);
    idle(3);
    pulse_start(1'b1);
    idle(3);
    frame(3'd2);
    for (int k = 0; k < 2; k++) begin
      chk(k, "single proc_start", 32'(proc_w[k]), 32'd1);
      chk(k, "single busy with proc", 32'(busy_w[k]), 32'd0);
      chk(k, "single slot0", 32'(s0_w[k]), 32'd4);
    end
    idle(10);
    for (int k = 0; k < 2; k++) chk(k, "single proc count", 32'(proc_cnt[k]), 32'd1);
    chk(0, "single no exp_req", 32'(vseq0.size()), 32'd0);
    chk(1, "single no exp_req", 32'(vseq1.size()), 32'd0);

    // ack timeout: exp_ack never arrives
    clear_mon();
    ack_dly[0] = 99; ack_dly[1] = 99;
    pulse_start(1'b1);
    idle(15);
    for (int k = 0; k < 2; k++) begin
      chk(k, "tmo cycle 16 req", 32'(req_w[k]), 32'd1);
      chk(k, "tmo cycle 16 err", 32'(eto_w[k]), 32'd0);
    end
    idle(1);
    for (int k = 0; k < 2; k++) begin
      chk(k, "tmo err_timeout", 32'(eto_w[k]), 32'd1);
      chk(k, "tmo exp_req", 32'(req_w[k]), 32'd0);
      chk(k, "tmo busy", 32'(busy_w[k]), 32'd0);
    end
    idle(4);
    for (int k = 0; k < 2; k++) chk(k, "tmo proc count", 32'(proc_cnt[k]), 32'd0);
    ack_dly[0] = 3; ack_dly[1] = 3;
    pulse_start(1'b0);
    for (int k = 0; k < 2; k++) chk(k, "start clears err_timeout", 32'(eto_w[k]), 32'd0);
    frame(3'd1);
    idle(2);
    frame(3'd2);
    idle(3);

    // randomized traffic
    for (int it = 0; it < 900; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        ack_dly[0] = pick_dly(); ack_dly[1] = pick_dly();
        pulse_start(1'($urandom_range(0, 1)));
      end else if (r == 2) begin
        @(negedge clk);
        start = 1'b1; hdr_en = 1'($urandom_range(0, 1));
        frame_done = 1'b1; last_frame = 3'($urandom_range(0, 5));
        @(negedge clk); start = 1'b0; frame_done = 1'b0;
      end else begin
        frame(3'($urandom_range(0, 5)));
      end
      idle($urandom_range(0, 9));
    end

    // asynchronous reset in the middle of an exposure write
    @(negedge clk); rst_n = 1'b0;
    idle(2); rst_n = 1'b1;
    ack_dly[0] = 99; ack_dly[1] = 99;
    idle(2);
    pulse_start(1'b1);
    idle(3);
    for (int k = 0; k < 2; k++) chk(k, "pre-reset exp_val", {15'd0, req_w[k], val_w[k]}, {15'd0, 1'b1, 16'h0040});
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals();
    idle(2);
    rst_n = 1'b1;
    ack_dly[0] = 3; ack_dly[1] = 3;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
